// File: rtl/alu_pkg.sv
// Shared types and constants for the 32-bit ALU execute stage.
// Opcode encodings, the buffered result entry, and the skid-buffer occupancy states.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             ne;
    logic             lt;
    logic             ovf;
    logic             illegal;
  } alu_result_t;

  // Occupancy doubles as the buffer state: the encoding equals the entry count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Upstream (operation) and downstream (result) handshakes of the ALU execute stage.
// master = the side that issues operations and consumes results; slave = the stage.
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [4:0]       in_shamt;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_ne;
  logic             out_lt;
  logic             out_ovf;
  logic             out_illegal;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_shamt, out_ready,
    input  in_ready, out_valid, out_result, out_ne, out_lt, out_ovf, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_shamt, out_ready,
    output in_ready, out_valid, out_result, out_ne, out_lt, out_ovf, out_illegal
  );

endinterface

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready FIFO of ALU result entries.
// in_ready depends only on the registered occupancy, so there is no out_ready -> in_ready path.
module alu_skid_buffer
  import alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  alu_result_t in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output alu_result_t out_data
);

  buf_state_t  state_reg, state_next;
  logic        head_reg, head_next;
  logic        tail_reg, tail_next;
  logic        push, pop;
  alu_result_t entries_reg [DEPTH];

  assign in_ready  = (state_reg != BUF_FULL);
  assign out_valid = (state_reg != BUF_EMPTY);
  assign out_data  = entries_reg[head_reg];

  always_comb begin
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (push) tail_next = ~tail_reg;
    if (pop)  head_next = ~head_reg;
    // Simultaneous push and pop leave the occupancy unchanged.
    case ({push, pop})
      2'b10:   state_next = (state_reg == BUF_EMPTY) ? BUF_ONE : BUF_FULL;
      2'b01:   state_next = (state_reg == BUF_FULL) ? BUF_ONE : BUF_EMPTY;
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= BUF_EMPTY;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  // Entries are cleared on reset so the presented head reads as all-zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
    end else if (push) begin
      entries_reg[tail_reg] <= in_data;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: combinational ADD/SUB/AND/OR/SLL/SRA feeding a
// two-entry skid buffer that presents result and flags to the writeback/branch stage.
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  alu_exec_stage_if.slave bus
);

  logic [WIDTH-1:0] a, b, sum, diff, sll_val, sra_val;
  logic [4:0]       shamt;
  logic             add_ovf, sub_ovf;
  alu_result_t      alu_out, head;

  assign a     = bus.in_a;
  assign b     = bus.in_b;
  assign shamt = bus.in_shamt;
  assign sum   = a + b;
  assign diff  = a - b;

  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Five log-shifter levels, level k moving by 2**k when shamt[k] is set.
  always_comb begin
    sll_val = a;
    sra_val = a;
    for (int lvl = 0; lvl < 5; lvl++) begin
      if (shamt[lvl]) begin
        sll_val = sll_val << (1 << lvl);
        sra_val = WIDTH'($signed(sra_val) >>> (1 << lvl));
      end
    end
  end

  always_comb begin
    alu_out = '0;
    case (bus.in_opcode)
      OP_ADD: begin
        alu_out.result = sum;
        alu_out.ovf    = add_ovf;
      end
      OP_SUB: begin
        alu_out.result = diff;
        alu_out.ovf    = sub_ovf;
        alu_out.lt     = diff[WIDTH-1] ^ sub_ovf;
        alu_out.ne     = |diff;
      end
      OP_AND:  alu_out.result = a & b;
      OP_OR:   alu_out.result = a | b;
      OP_SLL:  alu_out.result = sll_val;
      OP_SRA:  alu_out.result = sra_val;
      default: alu_out.illegal = 1'b1;
    endcase
  end

  alu_skid_buffer u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (alu_out),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head)
  );

  assign bus.out_result  = head.result;
  assign bus.out_ne      = head.ne;
  assign bus.out_lt      = head.lt;
  assign bus.out_ovf     = head.ovf;
  assign bus.out_illegal = head.illegal;

  // A stalled upstream must keep presenting the same operation.
  property p_hold_when_stalled;
    @(posedge clock) disable iff (!reset_n)
      (bus.in_valid && !bus.in_ready) |=>
        (bus.in_valid && $stable(bus.in_opcode) && $stable(bus.in_a) &&
         $stable(bus.in_b) && $stable(bus.in_shamt));
  endproperty
  a_hold_when_stalled: assert property (p_hold_when_stalled);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and random checks of alu_exec_stage: arithmetic/flags, shifts, illegal
// opcodes, backpressure through the skid buffer, reset while full, and an in-order stream.
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic alu_result_t model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    alu_result_t r;
    longint sa, sb, s;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0: begin
        r.result = a + b;
        s = sa + sb;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd1: begin
        r.result = a - b;
        s = sa - sb;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.lt  = (sa < sb);
        r.ne  = (a != b);
      end
      5'd2: r.result = a & b;
      5'd3: r.result = a | b;
      5'd4: r.result = a << sh;
      5'd5: r.result = $unsigned($signed(a) >>> sh);
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_shamt  = sh;
    bus.in_valid  = 1'b1;
    @(posedge clock); #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_a = '0; bus.in_b = '0;
    bus.in_shamt = '0; bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if ({bus.out_result, bus.out_ne, bus.out_lt, bus.out_ovf, bus.out_illegal} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs res=%h flags=%b%b%b%b required all zero", bus.out_result,
               bus.out_ne, bus.out_lt, bus.out_ovf, bus.out_illegal);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    $display("reset released");
  endtask

  task automatic test_arith;
    logic [4:0]  op [6]  = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
    logic [31:0] va [6]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'd5, 32'h80000000};
    logic [31:0] vb [6]  = '{32'h00000001, 32'h00000001, 32'h80000000, 32'h00000003, 32'd5, 32'h00000001};
    logic [31:0] res [6] = '{32'h80000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFB, 32'h0, 32'h7FFFFFFF};
    logic [3:0]  flg [6] = '{4'b0010, 4'b0000, 4'b0010, 4'b1100, 4'b0000, 4'b1110};
    alu_result_t obs, exp;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(op[i], va[i], vb[i], 5'd0);
      obs = {bus.out_result, bus.out_ne, bus.out_lt, bus.out_ovf, bus.out_illegal};
      exp = {res[i], flg[i]};
      checks++;
      if (bus.out_valid !== 1'b1 || obs !== exp) begin
        errors++;
        $display("FAIL arith[%0d] valid=%b res=%h ne/lt/ovf/ill=%b required valid=1 res=%h flags=%b",
                 i, bus.out_valid, obs.result, obs[3:0], exp.result, exp[3:0]);
      end else $display("arith[%0d] op=%0d a=%h b=%h res=%h flags=%b", i, op[i], va[i], vb[i],
                        obs.result, obs[3:0]);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arith_drain out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_logic_shift;
    logic [4:0]  op [9]  = '{OP_SRA, OP_SRA, OP_SLL, OP_SRA, OP_SRA, OP_SLL, OP_SRA, OP_AND, OP_OR};
    logic [31:0] va [9]  = '{32'h80000000, 32'h40000000, 32'h00000001, 32'h80000000, 32'hF0000000,
                             32'h12345678, 32'h7FFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0};
    logic [31:0] vb [9]  = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                             32'hDEADBEEF, 32'hDEADBEEF, 32'hFF00FF00, 32'hFF00FF00};
    logic [4:0]  sh [9]  = '{5'd31, 5'd30, 5'd31, 5'd0, 5'd4, 5'd4, 5'd31, 5'd3, 5'd7};
    logic [31:0] res [9] = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000, 32'hFF000000,
                             32'h23456780, 32'h00000000, 32'hF000F000, 32'hFFF0FFF0};
    alu_result_t obs;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(op[i], va[i], vb[i], sh[i]);
      obs = {bus.out_result, bus.out_ne, bus.out_lt, bus.out_ovf, bus.out_illegal};
      checks++;
      if (bus.out_valid !== 1'b1 || obs !== {res[i], 4'b0000}) begin
        errors++;
        $display("FAIL logic_shift[%0d] valid=%b res=%h flags=%b required valid=1 res=%h flags=0000",
                 i, bus.out_valid, obs.result, obs[3:0], res[i]);
      end else $display("logic_shift[%0d] op=%0d a=%h sh=%0d res=%h", i, op[i], va[i], sh[i], obs.result);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_illegal;
    logic [4:0] op [3] = '{5'b11111, 5'b00110, 5'b10000};
    alu_result_t obs;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(op[i], 32'h7FFFFFFF, 32'h00000001, 5'd3);
      obs = {bus.out_result, bus.out_ne, bus.out_lt, bus.out_ovf, bus.out_illegal};
      checks++;
      if (bus.out_valid !== 1'b1 || obs !== {32'h0, 4'b0001}) begin
        errors++;
        $display("FAIL illegal[%0d] valid=%b res=%h flags=%b required valid=1 res=00000000 flags=0001",
                 i, bus.out_valid, obs.result, obs[3:0]);
      end else $display("illegal[%0d] op=%b res=%h illegal=%b", i, op[i], obs.result, obs.illegal);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    bus.in_opcode = OP_ADD; bus.in_a = 32'd1; bus.in_b = 32'd2; bus.in_shamt = 5'd0;
    bus.in_valid  = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_result !== 32'd3) begin
      errors++;
      $display("FAIL bp_first in_ready=%b valid=%b res=%h required 1/1/00000003",
               bus.in_ready, bus.out_valid, bus.out_result);
    end
    bus.in_a = 32'd10; bus.in_b = 32'd20;
    @(posedge clock); #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full in_ready=%b required 0", bus.in_ready);
    end
    bus.in_opcode = OP_SUB; bus.in_a = 32'd100; bus.in_b = 32'd1;
    @(posedge clock); #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 32'd3) begin
      errors++;
      $display("FAIL bp_hold in_ready=%b res=%h required 0/00000003", bus.in_ready, bus.out_result);
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_result !== 32'd30) begin
      errors++;
      $display("FAIL bp_first_pop in_ready=%b valid=%b res=%h required 1/1/0000001e",
               bus.in_ready, bus.out_valid, bus.out_result);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd99 || bus.out_ne !== 1'b1) begin
      errors++;
      $display("FAIL bp_third valid=%b res=%h ne=%b required 1/00000063/1",
               bus.out_valid, bus.out_result, bus.out_ne);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain out_valid=%b required 0", bus.out_valid);
    end
    $display("backpressure sequence done");
  endtask

  task automatic test_reset_full;
    bus.out_ready = 1'b0;
    issue(OP_ADD, 32'd4, 32'd4, 5'd0);
    issue(OP_OR, 32'hA, 32'h5, 5'd0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstfull_fill in_ready=%b valid=%b required 0/1", bus.in_ready, bus.out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'd0) begin
      errors++;
      $display("FAIL rstfull_async valid=%b in_ready=%b res=%h required 0/1/00000000",
               bus.out_valid, bus.in_ready, bus.out_result);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    issue(OP_ADD, 32'd7, 32'd8, 5'd0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd15) begin
      errors++;
      $display("FAIL rstfull_after valid=%b res=%h required 1/0000000f", bus.out_valid, bus.out_result);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstfull_stale out_valid=%b required 0", bus.out_valid);
    end
    $display("reset while full done");
  endtask

  task automatic test_random;
    alu_result_t q[$];
    alu_result_t obs, exp;
    logic [4:0]  op;
    int sent = 0, got = 0, cyc = 0;
    logic acc_in, acc_out;
    bus.in_valid = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      if (!bus.in_valid && sent < 1000 && $urandom_range(0, 7) != 0) begin
        op = 5'($urandom_range(0, 7));
        if (op == 5'd7) op = 5'b11111;
        bus.in_opcode = op;
        bus.in_a      = $urandom;
        bus.in_b      = ($urandom_range(0, 3) == 0) ? bus.in_a : $urandom;
        bus.in_shamt  = 5'($urandom_range(0, 31));
        bus.in_valid  = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      acc_in  = bus.in_valid && bus.in_ready;
      acc_out = bus.out_valid && bus.out_ready;
      if (acc_out) begin
        obs = {bus.out_result, bus.out_ne, bus.out_lt, bus.out_ovf, bus.out_illegal};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL random_extra pop #%0d res=%h required no output", got, obs.result);
        end else begin
          exp = q.pop_front();
          if (obs !== exp) begin
            errors++;
            $display("FAIL random[%0d] res=%h flags=%b required res=%h flags=%b",
                     got, obs.result, obs[3:0], exp.result, exp[3:0]);
          end else $display("random[%0d] res=%h flags=%b", got, obs.result, obs[3:0]);
        end
        got++;
      end
      if (acc_in) begin
        q.push_back(model(bus.in_opcode, bus.in_a, bus.in_b, bus.in_shamt));
        sent++;
      end
      @(posedge clock); #1;
      if (acc_in) bus.in_valid = 1'b0;
      cyc++;
    end
    checks++;
    if (got != 1000 || sent != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL random_count got=%0d sent=%0d pending=%0d cycles=%0d required 1000/1000/0",
               got, sent, q.size(), cyc);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_shift();
    test_illegal();
    test_backpressure();
    test_reset_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
